// File: rtl/trapezoid_surf_accum.sv
// Sums per-segment trapezoid surfaces into one saturating total per frame and
// hands each finished total to the consumer through a one-entry valid/ready result register.
module trapezoid_surf_accum #(
   parameter int IN_W      = 32,
   parameter int ACC_W     = 48,
   parameter int CNT_W     = 16,
   parameter int OUT_SHIFT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  surf_in,
   input  logic             surf_valid,
   input  logic             surf_last,
   input  logic             clr,
   output logic [ACC_W-1:0] total,
   output logic [CNT_W-1:0] seg_count,
   output logic             total_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   output logic             dbg_acc_state,
   output logic             dbg_out_state
);

   // Handshake: a result transfers on any rising edge where out_valid & out_ready;
   // total/seg_count/total_ovf are held stable while out_valid & !out_ready.

   typedef enum logic {ACC_IDLE = 1'b0, ACC_RUN = 1'b1} acc_state_e;
   typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;

   localparam int SW = ACC_W + 1;

   acc_state_e       acc_state_q, acc_state_d;
   out_state_e       out_state_q, out_state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fovf_q, fovf_d;
   logic [ACC_W-1:0] total_q, total_d;
   logic [CNT_W-1:0] seg_q, seg_d;
   logic             tovf_q, tovf_d;
   logic             overrun_q, overrun_d;

   logic [SW-1:0]    sum_wide;
   logic             clamp;
   logic [ACC_W-1:0] sum_sat;
   logic [CNT_W-1:0] cnt_sat;
   logic             capture;

   // Single adder shared by the running sum and the frame-closing beat.
   assign sum_wide = {1'b0, acc_q} + {{(SW-IN_W){1'b0}}, surf_in};
   assign clamp    = sum_wide[ACC_W];
   assign sum_sat  = clamp ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
   assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   assign capture  = surf_valid & surf_last & ~clr;

   always_comb begin
      acc_state_d = acc_state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      fovf_d      = fovf_q;
      if (clr || (surf_valid && surf_last)) begin
         acc_state_d = ACC_IDLE;
         acc_d       = '0;
         cnt_d       = '0;
         fovf_d      = 1'b0;
      end else if (surf_valid) begin
         acc_state_d = ACC_RUN;
         acc_d       = sum_sat;
         cnt_d       = cnt_sat;
         fovf_d      = fovf_q | clamp;
      end
   end

   always_comb begin
      out_state_d = out_state_q;
      total_d     = total_q;
      seg_d       = seg_q;
      tovf_d      = tovf_q;
      overrun_d   = clr ? 1'b0 : overrun_q;
      case (out_state_q)
         OUT_EMPTY: begin
            if (capture) begin
               out_state_d = OUT_FULL;
               total_d     = sum_sat >> OUT_SHIFT;
               seg_d       = cnt_sat;
               tovf_d      = fovf_q | clamp;
            end
         end
         OUT_FULL: begin
            if (capture && out_ready) begin
               total_d = sum_sat >> OUT_SHIFT;
               seg_d   = cnt_sat;
               tovf_d  = fovf_q | clamp;
            end else if (capture) begin
               // Held result is not drained this cycle: the new frame is lost.
               overrun_d = 1'b1;
            end else if (out_ready) begin
               out_state_d = OUT_EMPTY;
            end
         end
         default: out_state_d = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_state_q <= ACC_IDLE;
         out_state_q <= OUT_EMPTY;
         acc_q       <= '0;
         cnt_q       <= '0;
         fovf_q      <= 1'b0;
         total_q     <= '0;
         seg_q       <= '0;
         tovf_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         acc_state_q <= acc_state_d;
         out_state_q <= out_state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         fovf_q      <= fovf_d;
         total_q     <= total_d;
         seg_q       <= seg_d;
         tovf_q      <= tovf_d;
         overrun_q   <= overrun_d;
      end
   end

   assign total         = total_q;
   assign seg_count     = seg_q;
   assign total_ovf     = tovf_q;
   assign out_valid     = (out_state_q == OUT_FULL);
   assign overrun       = overrun_q;
   assign dbg_acc_state = acc_state_q;
   assign dbg_out_state = out_state_q;

endmodule

// File: tb/tb_trapezoid_surf_accum.sv
// Drives three differently parameterised accumulators with one input stream and
// compares each against a frame-level model every cycle.
module tb_trapezoid_surf_accum;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] surf_in = '0;
   logic        surf_valid = 1'b0;
   logic        surf_last = 1'b0;
   logic        clr = 1'b0;
   logic        out_ready = 1'b0;

   logic [47:0] total0, total1;
   logic [32:0] total2;
   logic [15:0] seg0, seg1;
   logic [2:0]  seg2;
   logic        ovf0, ovf1, ovf2, ov0, ov1, ov2, orun0, orun1, orun2;
   logic        da0, da1, da2, do0, do1, do2;

   int total_checks = 0;
   int bad = 0;

   always #5 clk = ~clk;

   trapezoid_surf_accum #(.IN_W(32), .ACC_W(48), .CNT_W(16), .OUT_SHIFT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .surf_in(surf_in), .surf_valid(surf_valid),
      .surf_last(surf_last), .clr(clr), .total(total0), .seg_count(seg0),
      .total_ovf(ovf0), .out_valid(ov0), .out_ready(out_ready), .overrun(orun0),
      .dbg_acc_state(da0), .dbg_out_state(do0));
   trapezoid_surf_accum #(.IN_W(32), .ACC_W(48), .CNT_W(16), .OUT_SHIFT(4)) u1 (
      .clk(clk), .rst_n(rst_n), .surf_in(surf_in), .surf_valid(surf_valid),
      .surf_last(surf_last), .clr(clr), .total(total1), .seg_count(seg1),
      .total_ovf(ovf1), .out_valid(ov1), .out_ready(out_ready), .overrun(orun1),
      .dbg_acc_state(da1), .dbg_out_state(do1));
   trapezoid_surf_accum #(.IN_W(32), .ACC_W(33), .CNT_W(3), .OUT_SHIFT(0)) u2 (
      .clk(clk), .rst_n(rst_n), .surf_in(surf_in), .surf_valid(surf_valid),
      .surf_last(surf_last), .clr(clr), .total(total2), .seg_count(seg2),
      .total_ovf(ovf2), .out_valid(ov2), .out_ready(out_ready), .overrun(orun2),
      .dbg_acc_state(da2), .dbg_out_state(do2));

   // Reference model: exact frame sum and beat count, clamped only when a result is formed.
   int              p_acc[3] = '{48, 48, 33};
   int              p_cnt[3] = '{16, 16, 3};
   int              p_sh[3]  = '{0, 4, 0};
   longint unsigned f_sum;
   int              f_n;
   logic            e_valid[3];
   logic            e_orun[3];
   longint unsigned e_tot[3];
   longint unsigned e_seg[3];
   logic            e_ovf[3];

   task automatic model_reset();
      f_sum = 0;
      f_n   = 0;
      for (int i = 0; i < 3; i++) begin
         e_valid[i] = 1'b0; e_orun[i] = 1'b0; e_tot[i] = 0; e_seg[i] = 0; e_ovf[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      logic            cap;
      longint unsigned amax, cmax;
      cap = 1'b0;
      if (clr) begin
         f_sum = 0;
         f_n   = 0;
         for (int i = 0; i < 3; i++) e_orun[i] = 1'b0;
      end else if (surf_valid) begin
         f_sum += longint'(surf_in);
         f_n   += 1;
         cap    = surf_last;
      end
      for (int i = 0; i < 3; i++) begin
         amax = (64'd1 << p_acc[i]) - 1;
         cmax = (64'd1 << p_cnt[i]) - 1;
         if (cap) begin
            if (!e_valid[i] || out_ready) begin
               e_valid[i] = 1'b1;
               e_tot[i]   = ((f_sum > amax) ? amax : f_sum) >> p_sh[i];
               e_seg[i]   = (longint'(f_n) > cmax) ? cmax : longint'(f_n);
               e_ovf[i]   = (f_sum > amax);
            end else begin
               e_orun[i] = 1'b1;
            end
         end else if (e_valid[i] && out_ready) begin
            e_valid[i] = 1'b0;
         end
      end
      if (cap) begin
         f_sum = 0;
         f_n   = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_checks++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_inst(input int i, input logic [63:0] tot, input logic [63:0] seg,
                             input logic ovf, input logic vld, input logic orun);
      chk($sformatf("u%0d_out_valid", i), {63'd0, vld}, {63'd0, e_valid[i]});
      chk($sformatf("u%0d_overrun", i), {63'd0, orun}, {63'd0, e_orun[i]});
      chk($sformatf("u%0d_total", i), tot, e_tot[i]);
      chk($sformatf("u%0d_seg_count", i), seg, e_seg[i]);
      chk($sformatf("u%0d_total_ovf", i), {63'd0, ovf}, {63'd0, e_ovf[i]});
   endtask

   task automatic check_all();
      check_inst(0, {16'd0, total0}, {48'd0, seg0}, ovf0, ov0, orun0);
      check_inst(1, {16'd0, total1}, {48'd0, seg1}, ovf1, ov1, orun1);
      check_inst(2, {31'd0, total2}, {61'd0, seg2}, ovf2, ov2, orun2);
   endtask

   task automatic step(input logic v, input logic l, input logic [31:0] s,
                       input logic c, input logic r);
      surf_valid = v; surf_last = l; surf_in = s; clr = c; out_ready = r;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      surf_valid = 1'b0; surf_last = 1'b0; clr = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #2;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Three-beat frame drained immediately.
      step(1, 0, 32'd10, 0, 1);
      step(1, 0, 32'd20, 0, 1);
      step(1, 1, 32'd30, 0, 1);
      chk("t1_total", {16'd0, total0}, 64'd60);
      chk("t1_seg", {48'd0, seg0}, 64'd3);
      step(0, 0, 32'd0, 0, 1);
      chk("t1_valid_drop", {63'd0, ov0}, 64'd0);

      // Single-beat frame; u1 shifts right by 4.
      step(1, 1, 32'h0000_0100, 0, 1);
      chk("t2_total_shift", {16'd0, total1}, 64'h10);
      chk("t2_seg", {48'd0, seg1}, 64'd1);
      step(0, 0, 32'd0, 0, 1);

      // Held result, dropped frame, clr clears only overrun.
      step(1, 0, 32'd5, 0, 0);
      step(1, 1, 32'd5, 0, 0);
      step(0, 0, 32'd0, 0, 0);
      step(1, 1, 32'd7, 0, 0);
      chk("t3_total_held", {16'd0, total0}, 64'd10);
      chk("t3_overrun", {63'd0, orun0}, 64'd1);
      step(0, 0, 32'd0, 1, 0);
      chk("t3_overrun_clr", {63'd0, orun0}, 64'd0);
      chk("t3_total_after_clr", {16'd0, total0}, 64'd10);
      chk("t3_valid_after_clr", {63'd0, ov0}, 64'd1);

      // Capture coinciding with drain replaces the held result.
      step(1, 1, 32'd7, 0, 1);
      chk("t4_total", {16'd0, total0}, 64'd7);
      chk("t4_valid", {63'd0, ov0}, 64'd1);
      chk("t4_overrun", {63'd0, orun0}, 64'd0);
      step(0, 0, 32'd0, 0, 1);

      // Saturation of the 33-bit accumulator.
      step(1, 0, 32'hFFFF_FFFF, 0, 1);
      step(1, 0, 32'hFFFF_FFFF, 0, 1);
      step(1, 1, 32'hFFFF_FFFF, 0, 1);
      chk("t5_total_sat", {31'd0, total2}, 64'h1_FFFF_FFFF);
      chk("t5_ovf", {63'd0, ovf2}, 64'd1);
      chk("t5_seg", {61'd0, seg2}, 64'd3);
      chk("t5_total_wide", {16'd0, total0}, 64'h2_FFFF_FFFD);
      step(0, 0, 32'd0, 0, 1);

      // Reset mid-frame, then clr coincident with a beat.
      step(1, 0, 32'd1, 0, 1);
      step(1, 0, 32'd2, 0, 1);
      do_reset();
      step(1, 0, 32'd4, 0, 1);
      step(1, 1, 32'd4, 0, 1);
      chk("t6_total", {16'd0, total0}, 64'd8);
      chk("t6_seg", {48'd0, seg0}, 64'd2);
      step(1, 0, 32'd3, 0, 1);
      step(1, 0, 32'd100, 1, 1);
      step(1, 0, 32'd3, 0, 1);
      step(1, 1, 32'd6, 0, 1);
      chk("t6_clr_total", {16'd0, total0}, 64'd9);

      // Segment counter saturation on the 3-bit instance.
      for (int k = 0; k < 9; k++) step(1, (k == 8), 32'd1, 0, 1);
      chk("cnt_sat_u2", {61'd0, seg2}, 64'd7);
      chk("cnt_u0", {48'd0, seg0}, 64'd9);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom,
              $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
      end

      $display("test done: total=%0d bad=%0d", total_checks, bad);
      $finish;
   end

endmodule
